// File: rtl/bullet_pool.sv
// Pool of NUM_BULLETS bullets: spawn handshake, per-frame motion sweep, circle renderer.
// Optional target collision is enabled by defining BULLET_POOL_COLLIDE_EN.
module bullet_pool #(
  parameter int NUM_BULLETS = 8,
  parameter int COORD_W     = 10,
  parameter int RADIUS      = 4,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int COLOR_W     = 16
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               frame_tick,
  input  logic                               spawn_valid,
  output logic                               spawn_ready,
  input  logic [COORD_W-1:0]                 spawn_x,
  input  logic [COORD_W-1:0]                 spawn_y,
  input  logic [3:0]                         spawn_vx,
  input  logic [3:0]                         spawn_vy,
  input  logic [COLOR_W-1:0]                 spawn_color,
  input  logic [COORD_W-1:0]                 DrawX,
  input  logic [COORD_W-1:0]                 DrawY,
  output logic                               VGA_isObject,
  output logic [COLOR_W-1:0]                 VGA_Pixel,
  output logic [$clog2(NUM_BULLETS+1)-1:0]   active_count,
`ifdef BULLET_POOL_COLLIDE_EN
  input  logic [COORD_W-1:0]                 target_x,
  input  logic [COORD_W-1:0]                 target_y,
  input  logic [COORD_W-1:0]                 target_w,
  input  logic [COORD_W-1:0]                 target_h,
  output logic                               hit_pulse,
  output logic [$clog2(NUM_BULLETS)-1:0]     hit_index,
`endif
  output logic                               busy
);

  localparam int IDX_W = $clog2(NUM_BULLETS);
  localparam int CNT_W = $clog2(NUM_BULLETS+1);
  localparam int SQ_W  = 2*(COORD_W+2);
  localparam logic signed [COORD_W:0] POS_MIN = (COORD_W+1)'(-RADIUS);
  localparam logic signed [COORD_W:0] X_MAX   = (COORD_W+1)'(SCREEN_W-1+RADIUS);
  localparam logic signed [COORD_W:0] Y_MAX   = (COORD_W+1)'(SCREEN_H-1+RADIUS);
  localparam logic [SQ_W-1:0] R2 = SQ_W'(RADIUS*RADIUS);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [NUM_BULLETS-1:0]    active;
  logic signed [COORD_W:0]   pos_x [NUM_BULLETS];
  logic signed [COORD_W:0]   pos_y [NUM_BULLETS];
  logic signed [3:0]         vel_x [NUM_BULLETS];
  logic signed [3:0]         vel_y [NUM_BULLETS];
  logic [COLOR_W-1:0]        color [NUM_BULLETS];

  logic                      free_found;
  logic [IDX_W-1:0]          free_idx;
  logic                      spawn_fire;
  logic signed [COORD_W:0]   nx, ny;
  logic                      offscreen;
  logic [CNT_W-1:0]          pop_cnt;
  logic                      rnd_hit;
  logic [COLOR_W-1:0]        rnd_color;
  logic signed [COORD_W+1:0] dx, dy;
  logic [SQ_W-1:0]           dx_e, dy_e, dist_sq;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS-1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_ready = (state == IDLE) && free_found;
  assign spawn_fire  = spawn_valid && spawn_ready;
  assign busy        = (state == UPDATE);

  always_comb begin
    nx = pos_x[idx] + {{(COORD_W-3){vel_x[idx][3]}}, vel_x[idx]};
    ny = pos_y[idx] + {{(COORD_W-3){vel_y[idx][3]}}, vel_y[idx]};
    offscreen = (nx < POS_MIN) || (nx > X_MAX) || (ny < POS_MIN) || (ny > Y_MAX);
  end

`ifdef BULLET_POOL_COLLIDE_EN
  logic signed [COORD_W+1:0] nx_e, ny_e, tx_lo, tx_hi, ty_lo, ty_hi;
  logic                      in_target;

  always_comb begin
    nx_e  = {nx[COORD_W], nx};
    ny_e  = {ny[COORD_W], ny};
    tx_lo = {2'b00, target_x};
    ty_lo = {2'b00, target_y};
    tx_hi = {2'b00, target_x} + {2'b00, target_w};
    ty_hi = {2'b00, target_y} + {2'b00, target_h};
    in_target = (target_w != '0) && (target_h != '0) &&
                (nx_e >= tx_lo) && (nx_e < tx_hi) && (ny_e >= ty_lo) && (ny_e < ty_hi);
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      idx    <= '0;
      active <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
        color[i] <= '0;
      end
`ifdef BULLET_POOL_COLLIDE_EN
      hit_pulse <= 1'b0;
      hit_index <= '0;
`endif
    end else begin
`ifdef BULLET_POOL_COLLIDE_EN
      hit_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (spawn_fire) begin
            active[free_idx] <= 1'b1;
            pos_x[free_idx]  <= {1'b0, spawn_x};
            pos_y[free_idx]  <= {1'b0, spawn_y};
            vel_x[free_idx]  <= spawn_vx;
            vel_y[free_idx]  <= spawn_vy;
            color[free_idx]  <= spawn_color;
          end
          if (frame_tick) begin
            state <= UPDATE;
            idx   <= '0;
          end
        end
        UPDATE: begin
          if (active[idx]) begin
            pos_x[idx] <= nx;
            pos_y[idx] <= ny;
            if (offscreen) begin
              active[idx] <= 1'b0;
            end
`ifdef BULLET_POOL_COLLIDE_EN
            else if (in_target) begin
              active[idx] <= 1'b0;
              hit_pulse   <= 1'b1;
              hit_index   <= idx;
            end
`endif
          end
          if (idx == IDX_W'(NUM_BULLETS-1)) begin
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      pop_cnt = pop_cnt + CNT_W'(active[i]);
    end
  end

  // Walk high to low so the lowest-index hit overrides the others.
  always_comb begin
    rnd_hit   = 1'b0;
    rnd_color = '0;
    dx = '0; dy = '0; dx_e = '0; dy_e = '0; dist_sq = '0;
    for (int i = NUM_BULLETS-1; i >= 0; i--) begin
      dx      = {2'b00, DrawX} - {pos_x[i][COORD_W], pos_x[i]};
      dy      = {2'b00, DrawY} - {pos_y[i][COORD_W], pos_y[i]};
      dx_e    = {{(COORD_W+2){dx[COORD_W+1]}}, dx};
      dy_e    = {{(COORD_W+2){dy[COORD_W+1]}}, dy};
      dist_sq = dx_e*dx_e + dy_e*dy_e;
      if (active[i] && (dist_sq <= R2)) begin
        rnd_hit   = 1'b1;
        rnd_color = color[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_isObject <= 1'b0;
      VGA_Pixel    <= '0;
      active_count <= '0;
    end else begin
      VGA_isObject <= rnd_hit;
      VGA_Pixel    <= rnd_color;
      active_count <= pop_cnt;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus queues expected outputs, a negedge monitor checks them.
module tb_bullet_pool;
  localparam int NB = 8;

  localparam int K_OBJ  = 0;
  localparam int K_PIX  = 1;
  localparam int K_CNT  = 2;
  localparam int K_BUSY = 3;
  localparam int K_RDY  = 4;
  localparam int K_HIT  = 5;
  localparam int K_HIDX = 6;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick, spawn_valid, spawn_ready;
  logic [9:0]  spawn_x, spawn_y, DrawX, DrawY;
  logic [3:0]  spawn_vx, spawn_vy;
  logic [15:0] spawn_color, VGA_Pixel;
  logic        VGA_isObject, busy;
  logic [3:0]  active_count;
`ifdef BULLET_POOL_COLLIDE_EN
  logic [9:0]  target_x = 10'd300, target_y = 10'd100, target_w = 10'd20, target_h = 10'd20;
  logic        hit_pulse;
  logic [2:0]  hit_index;
`endif

  bullet_pool dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
    .spawn_color(spawn_color), .DrawX(DrawX), .DrawY(DrawY),
    .VGA_isObject(VGA_isObject), .VGA_Pixel(VGA_Pixel), .active_count(active_count),
`ifdef BULLET_POOL_COLLIDE_EN
    .target_x(target_x), .target_y(target_y), .target_w(target_w), .target_h(target_h),
    .hit_pulse(hit_pulse), .hit_index(hit_index),
`endif
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int    due;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wait_cnt = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int k);
    case (k)
      K_OBJ:  return {31'd0, VGA_isObject};
      K_PIX:  return {16'd0, VGA_Pixel};
      K_CNT:  return {28'd0, active_count};
      K_BUSY: return {31'd0, busy};
      K_RDY:  return {31'd0, spawn_ready};
`ifdef BULLET_POOL_COLLIDE_EN
      K_HIT:  return {31'd0, hit_pulse};
      K_HIDX: return {29'd0, hit_index};
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation that has come due after the last clock edge.
  always @(negedge Clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e   = q.pop_front();
      act = actual(e.kind);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic chk(logic [31:0] act, logic [31:0] exp, string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_push(int kind, int val, string name);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic probe(int x, int y, int obj, int pix, string nm);
    DrawX = 10'(x);
    DrawY = 10'(y);
    exp_push(K_OBJ, obj, {nm, "_obj"});
    exp_push(K_PIX, pix, {nm, "_pix"});
    step(1);
  endtask

  task automatic spawn(int x, int y, int vx, int vy, int col);
    spawn_x     = 10'(x);
    spawn_y     = 10'(y);
    spawn_vx    = 4'(vx);
    spawn_vy    = 4'(vy);
    spawn_color = 16'(col);
    spawn_valid = 1'b1;
    step(1);
    spawn_valid = 1'b0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(NB);
  endtask

  initial begin
    Reset = 1'b1;
    frame_tick = 0; spawn_valid = 0;
    spawn_x = 0; spawn_y = 0; spawn_vx = 0; spawn_vy = 0; spawn_color = 0;
    DrawX = 0; DrawY = 0;
    step(1);
    chk({28'd0, active_count}, 0, "rst_now_cnt");
    chk({31'd0, busy}, 0, "rst_now_busy");
    chk({31'd0, VGA_isObject}, 0, "rst_now_obj");
    chk({16'd0, VGA_Pixel}, 0, "rst_now_pix");
    chk({31'd0, spawn_ready}, 1, "rst_now_rdy");
    exp_push(K_CNT, 0, "rst_cnt");
    exp_push(K_BUSY, 0, "rst_busy");
    exp_push(K_OBJ, 0, "rst_obj");
    exp_push(K_PIX, 0, "rst_pix");
    exp_push(K_RDY, 1, "rst_rdy");
`ifdef BULLET_POOL_COLLIDE_EN
    exp_push(K_HIT, 0, "rst_hit");
`endif
    step(1);
    Reset = 1'b0;
    step(1);

    // spawn one bullet and render its edge pixels
    spawn(100, 200, 3, -2, 16'hF800);
    exp_push(K_CNT, 1, "spawn_cnt");
    probe(104, 200, 1, 16'hF800, "r_edge_in");
    probe(105, 200, 0, 0, "r_edge_out");

    // sweep: busy for exactly NB cycles, spawns refused meanwhile
    frame_tick = 1'b1;
    exp_push(K_BUSY, 1, "busy_c0");
    exp_push(K_RDY, 0, "rdy_c0");
    step(1);
    frame_tick = 1'b0;
    spawn_x = 10'd50; spawn_y = 10'd50; spawn_vx = 0; spawn_vy = 0; spawn_color = 16'h5555;
    spawn_valid = 1'b1;
    for (int i = 1; i < NB; i++) begin
      exp_push(K_BUSY, 1, $sformatf("busy_c%0d", i));
      exp_push(K_RDY, 0, $sformatf("rdy_c%0d", i));
      step(1);
    end
    spawn_valid = 1'b0;
    exp_push(K_BUSY, 0, "busy_end");
    exp_push(K_RDY, 1, "rdy_end");
    step(1);
    exp_push(K_CNT, 1, "sweep_cnt");
    probe(107, 198, 1, 16'hF800, "moved_in");
    probe(108, 198, 0, 0, "moved_out");
    probe(50, 50, 0, 0, "refused_spawn");

    // fill the pool
    spawn(400, 300, 0, 0, 16'h07E0);
    spawn(636, 100, 7, 0, 16'hFFFF);
    spawn(20, 20, 0, 0, 16'h1111);
    spawn(400, 300, 0, 0, 16'h001F);
    spawn(40, 20, 0, 0, 16'h2222);
    spawn(60, 20, 0, 0, 16'h3333);
    spawn(80, 20, 0, 0, 16'h4444);
    exp_push(K_RDY, 0, "full_rdy");
    exp_push(K_CNT, 8, "full_cnt");
    probe(400, 300, 1, 16'h07E0, "overlap_low_wins");
    probe(20, 20, 1, 16'h1111, "slot3_render");

    // slot2 sits at the right boundary after one tick, retires after the second
    frame();
    exp_push(K_RDY, 0, "edge_rdy");
    probe(643, 100, 1, 16'hFFFF, "edge_render");
    frame();
    exp_push(K_RDY, 1, "retired_rdy");
    exp_push(K_CNT, 7, "retired_cnt");
    probe(643, 100, 0, 0, "retired_render");
    spawn(500, 400, 0, 0, 16'hABCD);
    exp_push(K_RDY, 0, "refill_rdy");
    exp_push(K_CNT, 8, "refill_cnt");
    probe(500, 400, 1, 16'hABCD, "refill_render");

    // reset in the middle of a sweep
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(3);
    DrawX = 10'd400; DrawY = 10'd300;
    Reset = 1'b1;
    exp_push(K_CNT, 0, "abort_cnt");
    exp_push(K_BUSY, 0, "abort_busy");
    exp_push(K_OBJ, 0, "abort_obj");
    exp_push(K_PIX, 0, "abort_pix");
    step(1);
    Reset = 1'b0;
    exp_push(K_RDY, 1, "abort_rdy");
    exp_push(K_OBJ, 0, "abort_obj2");
    step(1);

    // bullet flying into the target region
    spawn(295, 105, 6, 0, 16'h7777);
    frame_tick = 1'b1;
`ifdef BULLET_POOL_COLLIDE_EN
    exp_push(K_HIT, 0, "hit_before");
`endif
    step(1);
    frame_tick = 1'b0;
`ifdef BULLET_POOL_COLLIDE_EN
    exp_push(K_HIT, 1, "hit_pulse");
    exp_push(K_HIDX, 0, "hit_index");
`endif
    step(1);
`ifdef BULLET_POOL_COLLIDE_EN
    exp_push(K_HIT, 0, "hit_after");
`endif
    step(NB - 2);
    exp_push(K_BUSY, 0, "tgt_idle");
    step(1);
`ifdef BULLET_POOL_COLLIDE_EN
    exp_push(K_CNT, 0, "tgt_cnt");
    probe(301, 105, 0, 0, "tgt_render");
`else
    exp_push(K_CNT, 1, "tgt_cnt");
    probe(301, 105, 1, 16'h7777, "tgt_render");
`endif

    wait_cnt = 0;
    while (busy && wait_cnt < NB + 2) begin
      step(1);
      wait_cnt++;
    end
    chk({31'd0, busy}, 0, "idle_wait_expired");

    step(3);
    chk(32'(q.size()), 0, "queue_drained");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
